// File: rtl/ram_ecc_scrub_pkg.sv
// ram_ecc_scrub_pkg: shared RAM geometry, scrubber FSM states and saturating increment
package ram_ecc_scrub_pkg;
  localparam int RAM_DEPTH  = 128;
  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 20;
  typedef enum logic [1:0] {S_WAIT, S_READ, S_CHECK, S_WB} scrub_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ram_ecc_sat_cnt.sv
// ram_ecc_sat_cnt: saturating event counter
// Ports: CLK, RESETN (async, active-low), i_inc (count one event), o_cnt (current count)
module ram_ecc_sat_cnt import ram_ecc_scrub_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) r_cnt <= '0;
    else if (i_inc) r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_W));
  assign o_cnt = r_cnt;
endmodule

// File: rtl/ram_ecc_scrub_ctrl.sv
// ram_ecc_scrub_ctrl: client/scrub arbiter and background ECC scrubber for the 128x20 ECC RAM
// Ports: CLK, RESETN (async, active-low); client read (c_rd_req, c_raddr -> c_rd_valid, c_rdata,
// c_rd_sb, c_rd_db); client write (c_wr_req, c_waddr, c_wdata); RAM drive (ram_raddr, ram_waddr,
// ram_wd, ram_wen) and returns (ram_rd, ram_sb_correct, ram_db_detect); scrub_en; status
// (sb_count, db_count, db_addr, db_irq, pass_done).
module ram_ecc_scrub_ctrl import ram_ecc_scrub_pkg::*; #(
  parameter int DEPTH          = RAM_DEPTH,
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter int DATA_W         = RAM_DATA_W,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              c_rd_req,
  input  logic [ADDR_W-1:0] c_raddr,
  output logic              c_rd_valid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rd_sb,
  output logic              c_rd_db,
  input  logic              c_wr_req,
  input  logic [ADDR_W-1:0] c_waddr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rd,
  input  logic              ram_sb_correct,
  input  logic              ram_db_detect,
  input  logic              scrub_en,
  output logic [CNT_W-1:0]  sb_count,
  output logic [CNT_W-1:0]  db_count,
  output logic [ADDR_W-1:0] db_addr,
  output logic              db_irq,
  output logic              pass_done
);
  localparam logic [15:0]       RELOAD    = 16'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  scrub_state_t      r_state;
  logic [15:0]       r_interval;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic [ADDR_W-1:0] r_db_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_rd_valid;
  logic              r_db_irq;
  logic              r_pass_done;
  logic              w_free;
  logic              w_hit;
  logic              w_sb;
  logic              w_db;
  logic              w_wb_fire;
  logic              w_adv;
  assign w_free    = !c_rd_req && !c_wr_req;
  // a client write to the word being scrubbed carries newer data, so it supersedes the write-back
  assign w_hit     = c_wr_req && (c_waddr == r_scrub_addr);
  assign w_db      = (r_state == S_CHECK) && ram_db_detect;
  assign w_sb      = (r_state == S_CHECK) && ram_sb_correct && !ram_db_detect;
  assign w_wb_fire = (r_state == S_WB) && !c_wr_req;
  assign w_adv     = ((r_state == S_CHECK) && !(w_sb && !w_hit)) ||
                     ((r_state == S_WB) && (w_wb_fire || w_hit));
  assign ram_raddr  = c_rd_req ? c_raddr : r_scrub_addr;
  assign ram_wen    = c_wr_req | w_wb_fire;
  assign ram_waddr  = c_wr_req ? c_waddr : r_scrub_addr;
  assign ram_wd     = c_wr_req ? c_wdata : r_wb_data;
  assign c_rd_valid = r_rd_valid;
  assign c_rdata    = ram_rd;
  assign c_rd_sb    = ram_sb_correct;
  assign c_rd_db    = ram_db_detect;
  assign db_addr    = r_db_addr;
  assign db_irq     = r_db_irq;
  assign pass_done  = r_pass_done;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state      <= S_WAIT;
      r_interval   <= RELOAD;
      r_scrub_addr <= '0;
      r_wb_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_db_addr    <= '0;
      r_db_irq     <= 1'b0;
      r_pass_done  <= 1'b0;
    end else begin
      r_rd_valid  <= c_rd_req;
      r_db_irq    <= w_db;
      r_pass_done <= w_adv && (r_scrub_addr == LAST_ADDR);
      if (w_db) r_db_addr <= r_scrub_addr;
      if (w_adv) r_scrub_addr <= (r_scrub_addr == LAST_ADDR) ? '0 : r_scrub_addr + 1'b1;
      case (r_state)
        S_WAIT: if (scrub_en) begin
          r_interval <= (r_interval == '0) ? RELOAD : r_interval - 1'b1;
          if (r_interval == '0) r_state <= S_READ;
        end
        S_READ: if (w_free) r_state <= S_CHECK;
        S_CHECK: begin
          if (w_sb && !w_hit) r_wb_data <= ram_rd;
          r_state <= (w_sb && !w_hit) ? S_WB : S_WAIT;
        end
        default: if (w_adv) r_state <= S_WAIT;
      endcase
    end
  end
  ram_ecc_sat_cnt #(.CNT_W(CNT_W)) u_sb_cnt (.CLK(CLK), .RESETN(RESETN), .i_inc(w_sb), .o_cnt(sb_count));
  ram_ecc_sat_cnt #(.CNT_W(CNT_W)) u_db_cnt (.CLK(CLK), .RESETN(RESETN), .i_inc(w_db), .o_cnt(db_count));
endmodule

// File: tb/tb_ram_ecc_scrub_ctrl.sv
// tb_ram_ecc_scrub_ctrl: scoreboard bench with a behavioural ECC RAM for ram_ecc_scrub_ctrl
module tb_ram_ecc_scrub_ctrl;
  localparam int AW = 7, DW = 20, N = 128, CW = 2;
  logic CLK = 1'b0, RESETN = 1'b1;
  always #5 CLK = ~CLK;
  logic c_rd_req, c_rd_valid, c_rd_sb, c_rd_db, c_wr_req, ram_wen, scrub_en, db_irq, pass_done;
  logic [AW-1:0] c_raddr, c_waddr, ram_raddr, ram_waddr, db_addr;
  logic [DW-1:0] c_rdata, c_wdata, ram_wd, ram_rd;
  logic ram_sb_correct, ram_db_detect;
  logic [CW-1:0] sb_count, db_count;
  ram_ecc_scrub_ctrl #(.SCRUB_INTERVAL(4), .CNT_W(CW)) dut (
    .CLK(CLK), .RESETN(RESETN), .c_rd_req(c_rd_req), .c_raddr(c_raddr), .c_rd_valid(c_rd_valid),
    .c_rdata(c_rdata), .c_rd_sb(c_rd_sb), .c_rd_db(c_rd_db), .c_wr_req(c_wr_req), .c_waddr(c_waddr),
    .c_wdata(c_wdata), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wd(ram_wd), .ram_wen(ram_wen),
    .ram_rd(ram_rd), .ram_sb_correct(ram_sb_correct), .ram_db_detect(ram_db_detect), .scrub_en(scrub_en),
    .sb_count(sb_count), .db_count(db_count), .db_addr(db_addr), .db_irq(db_irq), .pass_done(pass_done));
  logic [DW-1:0] gold [N];
  logic [DW-1:0] mem [N];
  int err [N];
  bit ram_init;
  bit inj_req;
  int inj_a, inj_k;
  always @(posedge CLK) begin
    ram_rd         <= (err[ram_raddr] == 2) ? mem[ram_raddr] ^ 20'h00005 : mem[ram_raddr];
    ram_sb_correct <= !ram_wen && err[ram_raddr] == 1;
    ram_db_detect  <= !ram_wen && err[ram_raddr] == 2;
    if (!ram_init) for (int i = 0; i < N; i++) begin mem[i] <= gold[i]; err[i] <= 0; end
    ram_init <= 1'b1;
    if (ram_wen) begin mem[ram_waddr] <= ram_wd; err[ram_waddr] <= 0; end
    if (inj_req) err[inj_a] <= inj_k;
  end
  typedef struct { logic [DW-1:0] d; logic sb; } rd_exp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wb_exp_t;
  rd_exp_t rdq[$];
  wb_exp_t wbq[$];
  logic [AW-1:0] dbq[$];
  int n_chk = 0, n_fail = 0, pass_cnt = 0;
  logic prev_irq = 1'b0;
  logic [AW-1:0] last_sa = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge CLK) begin
    rd_exp_t e;
    wb_exp_t w;
    if (c_rd_valid) begin
      chk("rd_pending", rdq.size() > 0, 1);
      if (rdq.size() > 0) begin
        e = rdq.pop_front();
        chk("rd_data", c_rdata, e.d);
        chk("rd_sb", c_rd_sb, e.sb);
        chk("rd_db", c_rd_db, 0);
      end
    end
    if (c_wr_req) begin
      chk("wr_en", ram_wen, 1);
      chk("wr_addr", ram_waddr, c_waddr);
      chk("wr_data", ram_wd, c_wdata);
    end else if (ram_wen) begin
      chk("wb_pending", wbq.size() > 0, 1);
      if (wbq.size() > 0) begin
        w = wbq.pop_front();
        chk("wb_addr", ram_waddr, w.a);
        chk("wb_data", ram_wd, w.d);
      end
    end
    if (!RESETN) begin
      last_sa = '0;
      prev_irq = 1'b0;
      pass_cnt = 0;
    end else begin
      if (db_irq) begin
        chk("db_irq_width", prev_irq, 0);
        chk("db_pending", dbq.size() > 0, 1);
        if (dbq.size() > 0) chk("db_addr", db_addr, dbq.pop_front());
      end
      prev_irq = db_irq;
      if (pass_done) pass_cnt++;
      if (!c_rd_req && ram_raddr != last_sa) begin
        chk("scrub_seq", ram_raddr, (int'(last_sa) + 1) % N);
        last_sa = ram_raddr;
      end
    end
  end
  task automatic drive(input bit rd, input int ra, input bit sb, input bit wr, input int wa, input logic [DW-1:0] wd);
    c_rd_req = rd; c_raddr = AW'(ra); c_wr_req = wr; c_waddr = AW'(wa); c_wdata = wd;
    if (rd) rdq.push_back('{d: gold[ra], sb: sb});
    if (wr) gold[wa] = wd;
  endtask
  task automatic step();
    @(posedge CLK); #1;
  endtask
  task automatic cyc(input bit rd, input int ra, input bit sb, input bit wr, input int wa, input logic [DW-1:0] wd);
    drive(rd, ra, sb, wr, wa, wd);
    step();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, '0);
  endtask
  task automatic inject(input int a, input int k);
    inj_a = a; inj_k = k; inj_req = 1'b1;
    idle(1);
    inj_req = 1'b0;
  endtask
  task automatic wait_scrub(input int a);
    int k = 0;
    while (ram_raddr != AW'(a) && k < 3000) begin idle(1); k++; end
    chk("scrub_reach", ram_raddr, a);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, '0);
    RESETN = 1'b0;
    #1;
    chk("rst_rd_valid", c_rd_valid, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_sb_count", sb_count, 0);
    chk("rst_db_count", db_count, 0);
    chk("rst_db_addr", db_addr, 0);
    chk("rst_db_irq", db_irq, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_raddr", ram_raddr, 0);
    step();
    RESETN = 1'b1;
  endtask
  initial begin
    scrub_en = 1'b1;
    for (int i = 0; i < N; i++) gold[i] = DW'($urandom);
    do_reset();
    // full idle pass: ordered addresses, single wrap pulse, no errors counted
    wait_scrub(127);
    wait_scrub(0);
    idle(8);
    chk("pass_cnt", pass_cnt, 1);
    chk("idle_sb_count", sb_count, 0);
    chk("idle_db_count", db_count, 0);
    // single-bit error at 5 is corrected by one write-back
    do_reset();
    inject(5, 1);
    wbq.push_back('{a: 7'd5, d: gold[5]});
    cyc(1, 5, 1, 0, 0, '0);
    wait_scrub(6);
    idle(3);
    chk("sb5_count", sb_count, 1);
    chk("sb5_wb_done", wbq.size(), 0);
    cyc(1, 5, 0, 0, 0, '0);
    idle(2);
    // double-bit error at 9: reported, never written back
    do_reset();
    inject(9, 2);
    dbq.push_back(7'd9);
    wait_scrub(10);
    idle(3);
    chk("db9_count", db_count, 1);
    chk("db9_addr", db_addr, 9);
    chk("db9_seen", dbq.size(), 0);
    cyc(0, 0, 0, 1, 9, DW'($urandom));
    // five double-bit errors saturate the 2-bit counter at 3
    do_reset();
    for (int a = 20; a < 25; a++) begin inject(a, 2); dbq.push_back(AW'(a)); end
    wait_scrub(25);
    idle(3);
    chk("db_sat_count", db_count, 3);
    chk("db_sat_addr", db_addr, 24);
    chk("db_sat_seen", dbq.size(), 0);
    for (int a = 20; a < 25; a++) cyc(0, 0, 0, 1, a, DW'($urandom));
    // write-back held off by client writes, fires on the first write-free cycle
    do_reset();
    inject(2, 1);
    wbq.push_back('{a: 7'd2, d: gold[2]});
    wait_scrub(2);
    idle(5);
    cyc(1, 60, 0, 1, 100, DW'($urandom));
    for (int i = 0; i < 3; i++) cyc(1, 40 + i, 0, 1, 90 + i, DW'($urandom));
    drive(1, 61, 0, 0, 0, '0);
    #1;
    chk("wb_first_free", {ram_wen, ram_waddr}, {1'b1, 7'd2});
    step();
    idle(3);
    chk("hold_sb_count", sb_count, 1);
    chk("hold_wb_done", wbq.size(), 0);
    cyc(1, 2, 0, 0, 0, '0);
    idle(2);
    // client write to the scrubbed word while in write-back cancels it
    do_reset();
    inject(3, 1);
    wait_scrub(3);
    idle(5);
    cyc(0, 0, 0, 1, 100, DW'($urandom));
    cyc(0, 0, 0, 1, 3, 20'hABCDE);
    idle(3);
    chk("cancel_sb_count", sb_count, 1);
    wait_scrub(4);
    cyc(1, 3, 0, 0, 0, '0);
    idle(2);
    // reset during write-back: no write, counters clear, scrub restarts at 0
    do_reset();
    inject(4, 1);
    wait_scrub(4);
    idle(5);
    cyc(0, 0, 0, 1, 100, DW'($urandom));
    cyc(0, 0, 0, 1, 101, DW'($urandom));
    chk("pre_rst_sb_count", sb_count, 1);
    do_reset();
    wbq.push_back('{a: 7'd4, d: gold[4]});
    wait_scrub(5);
    idle(3);
    chk("rescrub_sb_count", sb_count, 1);
    chk("rescrub_wb_done", wbq.size(), 0);
    // random client traffic with scrubbing toggled on and off
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit rd, wr;
      int ra, wa;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ra = $urandom_range(0, N - 1);
      wa = $urandom_range(0, N - 1);
      if (rd && wr && ra == wa) ra = (ra + 1) % N;
      if ($urandom_range(0, 15) == 0) scrub_en = !scrub_en;
      cyc(rd, ra, 0, wr, wa, DW'($urandom));
    end
    scrub_en = 1'b1;
    idle(3);
    chk("end_rdq_empty", rdq.size(), 0);
    chk("end_wbq_empty", wbq.size(), 0);
    chk("end_dbq_empty", dbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_ecc_scrub_ctrl.md
# ram_ecc_scrub_ctrl

Arbiter and background scrubber for the 128x20 ECC two-port RAM wrapper (`*_RAM_128x20_ECC`). It passes client reads and writes straight through with absolute priority. In idle port cycles it walks every word, and when the RAM flags a single-bit error it writes the RAM-corrected data back. It sits between the cache/tag client logic and the RAM wrapper, and exports error counters and status for the core's error reporting.

## Interface
Parameters:
- `DEPTH`, 128: words in the RAM.
- `ADDR_W`, 7: address width.
- `DATA_W`, 20: data width.
- `SCRUB_INTERVAL`, 1024: idle cycles between scrub reads. Legal range is 2..65535.
- `CNT_W`, 16: width of each error counter.

Ports (clock and reset first):
- `CLK` in 1: the single clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `c_rd_req` in 1: client read request.
- `c_raddr` in ADDR_W: client read address.
- `c_rd_valid` out 1: client read data valid.
- `c_rdata` out DATA_W: client read data.
- `c_rd_sb` / `c_rd_db` out 1: ECC flags returned with the client read.
- `c_wr_req` in 1: client write request.
- `c_waddr` in ADDR_W: client write address.
- `c_wdata` in DATA_W: client write data.
- `ram_raddr` out ADDR_W, `ram_waddr` out ADDR_W, `ram_wd` out DATA_W, `ram_wen` out 1: RAM wrapper read and write port drive.
- `ram_rd` in DATA_W, `ram_sb_correct` in 1, `ram_db_detect` in 1: RAM wrapper returns.
- `scrub_en` in 1: enables background scrubbing.
- `sb_count` out CNT_W: saturating count of corrected single-bit errors.
- `db_count` out CNT_W: saturating count of double-bit detections.
- `db_addr` out ADDR_W: address of the last double-bit detection.
- `db_irq` out 1: one-cycle pulse per double-bit detection.
- `pass_done` out 1: one-cycle pulse when the scrub address wraps from DEPTH-1 to 0.

## Operation
- Client requests are never stalled or rejected.
  - `ram_raddr` = `c_rd_req` ? `c_raddr` : `scrub_addr`.
  - `ram_wen` = `c_wr_req` | `wb_fire`.
  - `ram_waddr` and `ram_wd` select the client write when `c_wr_req` is high, and the scrub write-back otherwise.
- The RAM masks its ECC flags for a read issued in a cycle with `ram_wen`=1. The scrubber therefore issues a read only when `c_rd_req`=0 and `c_wr_req`=0.
- FSM states and transitions:
  - WAIT: the interval counter decrements while `scrub_en`=1. At 0 it reloads SCRUB_INTERVAL-1 and goes to READ.
  - READ: waits for a free cycle (no client request). In that cycle it drives `scrub_addr` and goes to CHECK.
  - CHECK: samples `ram_rd` and the flags.
    - SB: latch `ram_rd` (already corrected by the RAM), increment `sb_count`, go to WB.
    - DB: increment `db_count`, load `db_addr`=`scrub_addr`, pulse `db_irq`, advance the address, go to WAIT. No write-back.
    - Clean: advance the address, go to WAIT.
  - WB: `wb_fire` = !`c_wr_req`. On fire, advance the address and go to WAIT.
- Address advance wraps DEPTH-1 to 0 and pulses `pass_done` in the same cycle.
- Write-back cancel: a client write to `scrub_addr` in the READ-issue cycle, in CHECK, or while in WB cancels the write-back, because the client data is newer.
  - `sb_count` still counts the error.
  - The address advances and the FSM goes to WAIT.
- Counters saturate at 2^CNT_W-1 and are cleared only by reset.
- Dropping `scrub_en` holds WAIT and freezes the interval counter. An in-flight READ issue completes, and CHECK and WB run to completion.
- A client read and write to the same address in the same cycle returns undefined `c_rdata`; this is a client obligation.

## Timing
- Reset values:
  - All outputs 0: `c_rd_valid`, `ram_wen`, the counters, `db_addr`, `db_irq`, `pass_done`.
  - `ram_raddr` follows the mux, which is `scrub_addr`=0 at reset.
  - FSM in WAIT, interval counter loaded with SCRUB_INTERVAL-1, `scrub_addr`=0.
- The client path has zero added latency on the request side. `c_rd_valid` is `c_rd_req` registered once. `c_rdata`, `c_rd_sb` and `c_rd_db` wire directly from the RAM returns in the cycle `c_rd_valid` is high.
- Minimum scrub step is SCRUB_INTERVAL cycles in WAIT, plus 1 (READ), 1 (CHECK) and 1 (WB, SB only) with no client traffic.
- Reset asserted mid-operation aborts any pending write-back immediately; the RAM contents are untouched.

## Structure
- Package `ram_ecc_scrub_pkg` holds:
  - the FSM state enum (WAIT, READ, CHECK, WB);
  - DEPTH, ADDR_W and DATA_W constants;
  - the saturating-increment function.
- The `ram_ecc_scrub_ctrl` top contains the mux, FSM and interval counter.
- One sub-module, `ram_ecc_sat_cnt`, is instantiated twice, for SB and DB.

## Test plan
- Idle, SCRUB_INTERVAL=4, no errors injected:
  - scrub reads every address 0..127 in order;
  - `pass_done` pulses once at the wrap;
  - counters stay 0.
- Single-bit flip injected at address 5, scrub reaches it:
  - `sb_count`=1;
  - one write-back to address 5 with the corrected word;
  - a following client read of address 5 gives `c_rd_sb`=0.
- Double-bit flip at address 9:
  - `db_count`=1, `db_addr`=9, `db_irq` high for 1 cycle;
  - no `ram_wen` for address 9.
- Back-to-back client reads and writes during a pending SB write-back:
  - the client is never delayed;
  - the write-back fires on the first cycle with `c_wr_req`=0.
- Client write to `scrub_addr` while in WB:
  - write-back cancelled, so the RAM holds the client data;
  - `sb_count` still increments.
- `RESETN` pulsed low during WB:
  - all outputs return to reset values at once;
  - no scrub write occurs;
  - scrubbing restarts from address 0.
